// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF step scheduler.
package lif_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    UPDATE,
    WRITE,
    DONE
  } state_t;

  localparam int N_NEURONS_DEF = 4;
  localparam int IDX_W         = $clog2(N_NEURONS_DEF);
  localparam int REFRAC_W      = 3;

  // Leaked, integrated membrane value clamped to vmax; v - (v >> shift) never underflows.
  function automatic int unsigned sat_add(input int unsigned v,
                                          input int unsigned isyn,
                                          input int unsigned shift,
                                          input int unsigned vmax = 255);
    int unsigned sum;
    sum = v - (v >> shift) + isyn;
    return (sum > vmax) ? vmax : sum;
  endfunction

endpackage

// File: rtl/lif_step_scheduler_if.sv
// Synaptic-current fetch handshake and spike event bus of the LIF step scheduler.
interface lif_step_scheduler_if #(
  parameter int IDX_W = 2,
  parameter int V_W   = 8
);

  logic             isyn_req;
  logic [IDX_W-1:0] isyn_idx;
  logic             isyn_ack;
  logic [V_W-1:0]   isyn;
  logic             spike_valid;
  logic [IDX_W-1:0] spike_idx;

  modport master (
    output isyn_req, isyn_idx, spike_valid, spike_idx,
    input  isyn_ack, isyn
  );

  modport slave (
    input  isyn_req, isyn_idx, spike_valid, spike_idx,
    output isyn_ack, isyn
  );

endinterface

// File: rtl/lif_update_core.sv
// Registered UPDATE stage: leak, integrate, saturate, then resolve refractory/threshold.
module lif_update_core
  import lif_pkg::*;
#(
  parameter int          V_W          = 8,
  parameter int unsigned THRESH       = 200,
  parameter int unsigned LEAK_SHIFT   = 2,
  parameter int unsigned REFRAC_STEPS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [V_W-1:0]      v,
  input  logic [V_W-1:0]      isyn,
  input  logic [REFRAC_W-1:0] refrac,
  output logic [V_W-1:0]      next_v,
  output logic [REFRAC_W-1:0] next_refrac,
  output logic                fire
);

  localparam logic [V_W-1:0]      THRESH_V = V_W'(THRESH);
  localparam logic [REFRAC_W-1:0] REFRAC_V = REFRAC_W'(REFRAC_STEPS);

  logic [V_W-1:0] sat_sum;

  assign sat_sum = V_W'(sat_add(32'(v), 32'(isyn), LEAK_SHIFT, (32'd1 << V_W) - 32'd1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_v      <= '0;
      next_refrac <= '0;
      fire        <= 1'b0;
    end else if (en) begin
      if (refrac != '0) begin
        next_v      <= '0;
        next_refrac <= refrac - 1'b1;
        fire        <= 1'b0;
      end else if (sat_sum >= THRESH_V) begin
        next_v      <= '0;
        next_refrac <= REFRAC_V;
        fire        <= 1'b1;
      end else begin
        next_v      <= sat_sum;
        next_refrac <= '0;
        fire        <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lif_step_scheduler.sv
// Shares one LIF update datapath across N_NEURONS neurons, one timestep per tick.
// Optional LIF_SPIKE_COUNT_EN adds spike_count, the spike total of the last completed timestep.
module lif_step_scheduler
  import lif_pkg::*;
#(
  parameter int          N_NEURONS    = N_NEURONS_DEF,
  parameter int          V_W          = 8,
  parameter int unsigned THRESH       = 200,
  parameter int unsigned LEAK_SHIFT   = 2,
  parameter int unsigned REFRAC_STEPS = 2,
  localparam int         IW           = $clog2(N_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  tick,
  lif_step_scheduler_if.master  bus,
  output logic                  busy,
  output logic                  step_done,
  output logic                  overrun
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [IW:0]           spike_count
`endif
);

  state_t state, next_state;

  logic [IW-1:0]       idx;
  logic [V_W-1:0]      v_mem      [N_NEURONS];
  logic [REFRAC_W-1:0] refrac_mem [N_NEURONS];
  logic [V_W-1:0]      isyn_q;
  logic                isyn_req;
  logic                core_en;
  logic [V_W-1:0]      core_v;
  logic [REFRAC_W-1:0] core_refrac;
  logic                core_fire;
  logic                last_idx;
  logic                spike_valid_q;
  logic [IW-1:0]       spike_idx_q;

  assign last_idx = (idx == IW'(N_NEURONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    step_done  = 1'b0;
    isyn_req   = 1'b0;
    core_en    = 1'b0;
    case (state)
      IDLE:    if (ena && tick) next_state = FETCH;
      FETCH: begin
        isyn_req = 1'b1;
        if (ena && bus.isyn_ack) next_state = UPDATE;
      end
      UPDATE: begin
        core_en = ena;
        if (ena) next_state = WRITE;
      end
      WRITE:   if (ena) next_state = last_idx ? DONE : FETCH;
      DONE: begin
        step_done = ena;
        if (ena) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  lif_update_core #(
    .V_W          (V_W),
    .THRESH       (THRESH),
    .LEAK_SHIFT   (LEAK_SHIFT),
    .REFRAC_STEPS (REFRAC_STEPS)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .en          (core_en),
    .v           (v_mem[idx]),
    .isyn        (isyn_q),
    .refrac      (refrac_mem[idx]),
    .next_v      (core_v),
    .next_refrac (core_refrac),
    .fire        (core_fire)
  );

  // NOTE: neuron state arrays are reset because a reset must restart every neuron from rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      isyn_q <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i]      <= '0;
        refrac_mem[i] <= '0;
      end
    end else if (ena) begin
      case (state)
        IDLE:    if (tick) idx <= '0;
        FETCH:   if (bus.isyn_ack) isyn_q <= bus.isyn;
        WRITE: begin
          v_mem[idx]      <= core_v;
          refrac_mem[idx] <= core_refrac;
          if (!last_idx) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Event pulses last one cycle even while ena holds the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      overrun       <= 1'b0;
    end else begin
      spike_valid_q <= ena && (state == WRITE) && core_fire;
      if (ena && (state == WRITE) && core_fire) spike_idx_q <= idx;
      overrun <= tick && ena && (state != IDLE);
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [IW:0] step_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt    <= '0;
      spike_count <= '0;
    end else if (ena) begin
      if (state == WRITE && core_fire) begin
        step_cnt <= step_cnt + 1'b1;
      end else if (state == DONE) begin
        step_cnt    <= '0;
        spike_count <= step_cnt;
      end
    end
  end
`endif

  assign bus.isyn_req    = isyn_req;
  assign bus.isyn_idx    = idx;
  assign bus.spike_valid = spike_valid_q;
  assign bus.spike_idx   = spike_idx_q;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Directed bench for lif_step_scheduler: a behavioural LIF model feeds a spike scoreboard.
module tb_lif_step_scheduler;
  import lif_pkg::*;

  localparam int N      = 4;
  localparam int VMAX   = 255;
  localparam int THR    = 200;
  localparam int LSHIFT = 2;
  localparam int REFR   = 2;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic ena  = 1'b0;
  logic tick = 1'b0;
  logic busy, step_done, overrun;
`ifdef LIF_SPIKE_COUNT_EN
  logic [IDX_W:0] spike_count;
`endif

  lif_step_scheduler_if #(.IDX_W(IDX_W), .V_W(8)) bus ();

  lif_step_scheduler #(
    .N_NEURONS    (N),
    .V_W          (8),
    .THRESH       (THR),
    .LEAK_SHIFT   (LSHIFT),
    .REFRAC_STEPS (REFR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .tick        (tick),
    .bus         (bus),
    .busy        (busy),
    .step_done   (step_done),
    .overrun     (overrun)
`ifdef LIF_SPIKE_COUNT_EN
    ,
    .spike_count (spike_count)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_errors  = 0;
  logic [7:0] cur [N];
  int         delay_idx = -1;
  logic [7:0] vm [N];
  logic [2:0] rm [N];
  int         sb [$];
  int         exp_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_isyn_req"},    32'(bus.isyn_req),    0);
    chk({tag, "_isyn_idx"},    32'(bus.isyn_idx),    0);
    chk({tag, "_spike_valid"}, 32'(bus.spike_valid), 0);
    chk({tag, "_spike_idx"},   32'(bus.spike_idx),   0);
    chk({tag, "_busy"},        32'(busy),            0);
    chk({tag, "_step_done"},   32'(step_done),       0);
    chk({tag, "_overrun"},     32'(overrun),         0);
`ifdef LIF_SPIKE_COUNT_EN
    chk({tag, "_spike_count"}, 32'(spike_count),     0);
`endif
  endtask

  // Reference LIF timestep over the currents in cur[]; queues the expected spikes.
  task automatic model_step();
    int s;
    for (int i = 0; i < N; i++) begin
      if (rm[i] != 0) begin
        vm[i] = 8'd0;
        rm[i] = rm[i] - 3'd1;
      end else begin
        s = int'(vm[i]) - int'(vm[i] >> LSHIFT) + int'(cur[i]);
        if (s > VMAX) s = VMAX;
        if (s >= THR) begin
          vm[i] = 8'd0;
          rm[i] = 3'(REFR);
          sb.push_back(i);
          exp_cnt++;
        end else begin
          vm[i] = 8'(s);
        end
      end
    end
  endtask

  // Current source: ack high except for 3 wait cycles on neuron delay_idx.
  initial begin
    int wait_cnt;
    wait_cnt      = 0;
    bus.isyn_ack  = 1'b1;
    bus.isyn      = 8'd0;
    forever begin
      @(negedge clk);
      if (bus.isyn_req && int'(bus.isyn_idx) == delay_idx && wait_cnt < 3) begin
        bus.isyn_ack = 1'b0;
        wait_cnt++;
      end else begin
        bus.isyn_ack = 1'b1;
        if (!(bus.isyn_req && int'(bus.isyn_idx) == delay_idx)) wait_cnt = 0;
      end
      bus.isyn = cur[bus.isyn_idx];
    end
  end

  // Spike monitor: every spike must match the scoreboard head and land in FETCH or DONE.
  initial begin
    int exp_idx;
    forever begin
      @(negedge clk);
      if (bus.spike_valid === 1'b1) begin
        exp_idx = (sb.size() > 0) ? sb.pop_front() : 99;
        chk("spike_idx", 32'(bus.spike_idx), 32'(exp_idx));
        chk("spike_slot", 32'(bus.isyn_req | step_done), 1);
      end
    end
  end

  task automatic run_step(input logic [7:0] c0, input logic [7:0] c1,
                          input logic [7:0] c2, input logic [7:0] c3,
                          input int exp_lat, input int ovr_at, input int ack_dly,
                          input int ena_low_at, input int rst_at, input bit tick_at_done);
    int n;
    int exp_fetch;
    bit done;
    cur[0] = c0; cur[1] = c1; cur[2] = c2; cur[3] = c3;
    delay_idx = ack_dly;
    exp_cnt   = 0;
    if (rst_at == 0) model_step();
    @(negedge clk);
    tick      = 1'b1;
    n         = 0;
    exp_fetch = 0;
    done      = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      tick = 1'b0;
      if (ena_low_at > 0 && n == ena_low_at)     ena = 1'b0;
      if (ena_low_at > 0 && n == ena_low_at + 3) ena = 1'b1;
      #1;
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        done = 1'b1;
      end else begin
        chk("busy", 32'(busy), 1);
        chk("overrun", 32'(overrun), (ovr_at > 0 && n == ovr_at + 1) ? 1 : 0);
        if (!ena) chk("req_hold", 32'(bus.isyn_req), 1);
        if (bus.isyn_req && bus.isyn_ack && ena) begin
          chk("fetch_idx", 32'(bus.isyn_idx), 32'(exp_fetch));
          exp_fetch++;
        end
        if (n == ovr_at) tick = 1'b1;
        if (step_done) begin
          done = 1'b1;
          chk("latency", 32'(n), 32'(exp_lat));
          chk("fetch_count", 32'(exp_fetch), N);
          if (tick_at_done) tick = 1'b1;
        end
      end
    end
    if (!done) chk("step_timeout", 32'(n), 32'(exp_lat));
    delay_idx = -1;
    if (rst_at > 0) begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
        vm[i] = 8'd0;
        rm[i] = 3'd0;
      end
      sb.delete();
      return;
    end
    @(negedge clk);
    tick = 1'b0;
    #1;
    chk("overrun_after", 32'(overrun), 32'(tick_at_done));
    chk("busy_after", 32'(busy), 0);
    chk("step_done_width", 32'(step_done), 0);
    chk("missed_spikes", 32'(sb.size()), 0);
`ifdef LIF_SPIKE_COUNT_EN
    chk("spike_count", 32'(spike_count), 32'(exp_cnt));
`endif
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      cur[i] = 8'd0;
      vm[i]  = 8'd0;
      rm[i]  = 3'd0;
    end
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b1;

    // n2 hits THRESH exactly; n0 integrates 100/175/232; n1 saturates 387 -> 255 in step 3.
    run_step(8'd100, 8'd100, 8'd200, 8'd199, 13, 0, -1, 0, 0, 1'b0);
    run_step(8'd100, 8'd100, 8'd0,   8'd0,   13, 0, -1, 0, 0, 1'b0);
    run_step(8'd100, 8'd255, 8'd0,   8'd0,   13, 0, -1, 0, 0, 1'b0);
    // Refractory n0 ignores 255 twice, then fires; step 4 also sees a tick in cycle 5.
    run_step(8'd255, 8'd0,   8'd0,   8'd0,   13, 5, -1, 0, 0, 1'b0);
    run_step(8'd255, 8'd0,   8'd0,   8'd0,   16, 0,  2, 0, 0, 1'b0);
    run_step(8'd255, 8'd0,   8'd0,   8'd0,   13, 0, -1, 0, 0, 1'b1);
    // ena low for 3 cycles while fetching neuron 1.
    run_step(8'd0,   8'd0,   8'd0,   8'd0,   16, 0, -1, 4, 0, 1'b0);
    run_step(8'd0,   8'd0,   8'd199, 8'd200, 13, 0, -1, 0, 0, 1'b0);
    // Reset during WRITE of neuron 1; n2 would fire next step had v survived.
    run_step(8'd0,   8'd0,   8'd0,   8'd0,   0,  0, -1, 0, 6, 1'b0);
    run_step(8'd0,   8'd0,   8'd100, 8'd0,   13, 0, -1, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

endmodule
